// File: rtl/pll_lock_detect.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_detect
// Description : Counts CLK cycles per REF period and flags frequency lock
//               and loss of reference.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_detect #(
    parameter int unsigned MULT     = 8,
    parameter int unsigned TOL      = 1,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned CW       = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REF,
    input  logic          EN,
    output logic [CW-1:0] MEAS,
    output logic          MEAS_VALID,
    output logic          LOCK,
    output logic          REF_LOST
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0] c_cnt_max  = '1;
    localparam logic [CW-1:0] c_timeout  = CW'(TIMEOUT);
    localparam logic [CW:0]   c_mult     = (CW+1)'(MULT);
    localparam logic [CW:0]   c_tol      = (CW+1)'(TOL);
    localparam logic [CW:0]   c_hi       = c_mult + c_tol;
    localparam logic [GW-1:0] c_lock_cnt = GW'(LOCK_CNT);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_armed = 1'b1;

    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gc;
    logic [0:0]    r_state;
    logic [CW-1:0] r_meas;
    logic          r_meas_valid;
    logic          r_lock;
    logic          r_ref_lost;

    logic [0:0]    w_state_next;
    logic          w_armed;
    logic          w_ref_rise;
    logic          w_timeout;
    logic          w_good;
    logic [GW-1:0] w_gc_inc;
    logic [CW:0]   w_cnt_ext;

    // REF synchroniser plus edge-detect stage; the fixed latency cancels out
    // of the period measurement.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= REF;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_ref_rise = r_s2 & ~r_s3;
    assign w_timeout  = EN & ~w_ref_rise & (r_cnt == c_timeout);
    assign w_cnt_ext  = {1'b0, r_cnt};
    // Lower bound tested as cnt+TOL >= MULT so it cannot wrap when TOL > MULT.
    assign w_good     = ((w_cnt_ext + c_tol) >= c_mult) && (w_cnt_ext <= c_hi);
    assign w_gc_inc   = (r_gc == c_lock_cnt) ? r_gc : r_gc + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!EN) begin
            w_state_next = c_st_idle;
        end else if (w_ref_rise) begin
            w_state_next = c_st_armed;
        end else if (w_timeout) begin
            w_state_next = c_st_idle;
        end
    end

    always_comb begin
        w_armed = (r_state == c_st_armed);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt        <= '0;
            r_gc         <= '0;
            r_meas       <= '0;
            r_meas_valid <= 1'b0;
            r_lock       <= 1'b0;
            r_ref_lost   <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if (!EN) begin
                r_cnt  <= '0;
                r_gc   <= '0;
                r_lock <= 1'b0;
            end else if (w_ref_rise) begin
                r_cnt      <= CW'(1);
                r_ref_lost <= 1'b0;
                if (w_armed) begin
                    r_meas       <= r_cnt;
                    r_meas_valid <= 1'b1;
                    if (w_good) begin
                        r_gc   <= w_gc_inc;
                        r_lock <= (w_gc_inc == c_lock_cnt);
                    end else begin
                        r_gc   <= '0;
                        r_lock <= 1'b0;
                    end
                end
            end else begin
                if (r_cnt != c_cnt_max) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_timeout) begin
                    r_ref_lost <= 1'b1;
                    r_lock     <= 1'b0;
                    r_gc       <= '0;
                end
            end
        end
    end

    assign MEAS       = r_meas;
    assign MEAS_VALID = r_meas_valid;
    assign LOCK       = r_lock;
    assign REF_LOST   = r_ref_lost;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_detect
// Description : Directed bench for pll_lock_detect with REF driven on the
//               falling CLK edge so every period is an exact cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_detect;

    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REF;
    logic          EN;
    logic [CW-1:0] MEAS;
    logic          MEAS_VALID;
    logic          LOCK;
    logic          REF_LOST;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;

    always #5 CLK = ~CLK;

    pll_lock_detect #(
        .MULT    (8),
        .TOL     (1),
        .LOCK_CNT(4),
        .TIMEOUT (64),
        .CW      (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REF       (REF),
        .EN        (EN),
        .MEAS      (MEAS),
        .MEAS_VALID(MEAS_VALID),
        .LOCK      (LOCK),
        .REF_LOST  (REF_LOST)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One REF rising edge followed by p-1 low cycles; the MEAS_VALID pulse for
    // this edge lands inside the same window (3 edges of synchroniser delay).
    task automatic ref_edge(input int p, input int exp_mv, input int exp_meas, input int exp_lock);
        int            mv_cnt;
        logic [CW-1:0] seen;
        mv_cnt = 0;
        seen   = MEAS;
        edge_no++;
        REF = 1'b1;
        for (int j = 0; j < p; j++) begin
            @(negedge CLK);
            if (j == 0) REF = 1'b0;
            if (MEAS_VALID === 1'b1) begin
                mv_cnt++;
                seen = MEAS;
            end
        end
        check($sformatf("edge%0d_mv", edge_no), mv_cnt, exp_mv);
        if (exp_mv != 0) check($sformatf("edge%0d_meas", edge_no), {24'd0, seen}, exp_meas);
        check($sformatf("edge%0d_lock", edge_no), {31'd0, LOCK}, exp_lock);
        check($sformatf("edge%0d_reflost", edge_no), {31'd0, REF_LOST}, 0);
    endtask

    initial begin
        RST = 1'b1;
        REF = 1'b0;
        EN  = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_meas", {24'd0, MEAS}, 0);
        check("reset_mv", {31'd0, MEAS_VALID}, 0);
        check("reset_lock", {31'd0, LOCK}, 0);
        check("reset_reflost", {31'd0, REF_LOST}, 0);
        RST = 1'b0;
        EN  = 1'b1;

        // Nominal 8-cycle periods: first edge arms, lock after 4 good windows.
        ref_edge(8, 0, 0, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 1);
        // One 10-cycle period drops lock on its update; four good ones restore it.
        ref_edge(10, 1, 8, 1);
        ref_edge(8, 1, 10, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 1);
        // Tolerance edges: 7 and 9 good, 6 and 10 bad.
        ref_edge(7, 1, 8, 1);
        ref_edge(9, 1, 7, 1);
        ref_edge(6, 1, 9, 1);
        ref_edge(8, 1, 6, 0);
        ref_edge(7, 1, 8, 0);
        ref_edge(9, 1, 7, 0);
        ref_edge(7, 1, 9, 0);
        ref_edge(8, 1, 7, 1);
        ref_edge(10, 1, 8, 1);
        ref_edge(8, 1, 10, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 1);

        // Hold REF low: the last edge acted just before the 3rd sampled negedge.
        repeat (58) @(negedge CLK);
        check("timeout_minus1_reflost", {31'd0, REF_LOST}, 0);
        check("timeout_minus1_lock", {31'd0, LOCK}, 1);
        @(negedge CLK);
        check("timeout_reflost", {31'd0, REF_LOST}, 1);
        check("timeout_lock", {31'd0, LOCK}, 0);
        ref_edge(8, 0, 0, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 1);

        // Short EN drop while locked.
        EN = 1'b0;
        repeat (3) @(negedge CLK);
        check("en_off_lock", {31'd0, LOCK}, 0);
        check("en_off_meas", {24'd0, MEAS}, 8);
        check("en_off_mv", {31'd0, MEAS_VALID}, 0);
        EN = 1'b1;
        ref_edge(8, 0, 0, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 1);

        // Period exactly TIMEOUT: the edge wins over the timeout, bad window.
        ref_edge(64, 1, 8, 1);
        ref_edge(8, 1, 64, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 0);
        ref_edge(8, 1, 8, 1);

        // Asynchronous reset between CLK edges clears outputs at once.
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_meas", {24'd0, MEAS}, 0);
        check("async_rst_mv", {31'd0, MEAS_VALID}, 0);
        check("async_rst_lock", {31'd0, LOCK}, 0);
        check("async_rst_reflost", {31'd0, REF_LOST}, 0);
        @(negedge CLK);
        RST = 1'b0;
        ref_edge(8, 0, 0, 0);
        ref_edge(8, 1, 8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pll_lock_detect.md
Name: pll_lock_detect

Overview:
Digital lock/frequency monitor for the on-chip PLL clock. It runs in the PLL output domain (CLK) and samples the reference (REF) through a synchroniser. It measures the number of CLK cycles per REF period and compares that count against the expected multiplication ratio. It asserts LOCK after a run of consecutive in-tolerance periods and flags REF_LOST when REF stops toggling.

Parameters:
MULT, 8, expected CLK cycles per REF period (PLL ratio)
TOL, 1, allowed absolute deviation of the measured period from MULT, in CLK cycles
LOCK_CNT, 4, consecutive good periods required to assert LOCK (>=1)
TIMEOUT, 64, CLK cycles without a REF edge before REF_LOST; must satisfy MULT+TOL < TIMEOUT <= 2^CW-1
CW, 8, width of the period counter and MEAS

Ports:
CLK  in  1  PLL output clock; all logic runs on its rising edge
RST  in  1  asynchronous, active-high reset
REF  in  1  reference clock, asynchronous to CLK
EN  in  1  monitor enable, synchronous to CLK
MEAS  out  CW  last measured REF period in CLK cycles
MEAS_VALID  out  1  one-cycle pulse when MEAS updates
LOCK  out  1  frequency lock indicator
REF_LOST  out  1  reference timeout indicator

Behaviour:
- Reset (RST=1, async): synchroniser flops, edge-detect flop, cnt, good count and armed flag cleared. Outputs: MEAS=0, MEAS_VALID=0, LOCK=0, REF_LOST=0.
- REF path: 2-flop synchroniser, then a third flop for edge detect. ref_rise = s2 & ~s3.
- ref_rise is a 1-cycle pulse, 3 CLK edges after REF rises (synchroniser latency). This latency is the same for every edge, so it does not affect the measured period.
- cnt (CW bits):
  - On ref_rise: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at 2^CW-1.
  - Period P = number of CLK cycles between consecutive ref_rise pulses = cnt value sampled on the ref_rise cycle.
- armed flag: set by any ref_rise. Cleared by reset, by timeout, and while EN=0.
- On ref_rise with armed=1:
  - MEAS <= cnt; MEAS_VALID <= 1 in the next cycle (registered, 1-cycle pulse).
  - Window is good iff MEAS lies within [MULT-TOL, MULT+TOL] inclusive. Compute this in CW+1-bit arithmetic so MULT-TOL cannot underflow.
  - Good window: gc <= min(gc+1, LOCK_CNT). LOCK <= 1 when the new gc equals LOCK_CNT.
  - Bad window: gc <= 0, LOCK <= 0. Loss of lock takes effect on the same update as the bad MEAS (no hysteresis).
- On ref_rise with armed=0:
  - No measurement, MEAS_VALID stays 0, MEAS holds its value.
  - armed <= 1, REF_LOST <= 0.
- Timeout: when cnt == TIMEOUT and there is no ref_rise this cycle:
  - REF_LOST <= 1, LOCK <= 0, gc <= 0, armed <= 0.
  - cnt keeps counting and saturates.
  - REF_LOST holds until the next ref_rise, which clears it and only re-arms; it takes no measurement.
- Simultaneous ref_rise and cnt == TIMEOUT: ref_rise wins. It is treated as a normal edge, and P=TIMEOUT is a bad window.
- EN=0: cnt <= 0, gc <= 0, armed <= 0, LOCK <= 0, MEAS_VALID <= 0. MEAS and REF_LOST hold. Synchroniser keeps running.
- EN 0->1: the first ref_rise only arms; the second ref_rise produces the first MEAS.
- RST asserted mid-measurement: immediate clear as at reset. The first post-reset edge only arms.
- MEAS_VALID never asserts on two consecutive cycles: consecutive ref_rise pulses are at least 2 cycles apart because of the edge detector.
- LOCK is glitch-free (registered) and changes only on a measurement cycle, a timeout or EN/RST.

Test Plan:
- Reset, EN=1, REF period = 8 CLK, 6 REF edges -> first edge arms; MEAS=8 with MEAS_VALID pulses on edges 2-6. LOCK rises one cycle after the 5th edge's ref_rise (4th good window).
- Locked, then a single REF period of 10 CLK -> MEAS=10, LOCK drops on that update. Four further 8-CLK periods re-assert LOCK.
- Periods of 7 and 9 CLK (TOL=1) -> counted good, LOCK after 4. Periods of 6 or 10 -> gc cleared, LOCK=0.
- Locked, REF held low -> REF_LOST=1 and LOCK=0 exactly 64 cycles after the last ref_rise. Resume 8-CLK periods -> next edge clears REF_LOST with no MEAS_VALID; LOCK 4 good periods later.
- Locked, pulse EN=0 for 3 cycles -> LOCK=0, MEAS holds 8. After EN=1, first edge arms, LOCK returns after 4 good windows.
- Assert RST asynchronously between CLK edges while locked -> all outputs 0 immediately, before the next CLK edge. The first post-reset REF edge produces no MEAS_VALID.
